rice_bus_arbiter: RTL and testbench

RICE_BUS_ARBITER -- requirements
Module: rice_bus_arbiter

---
 rtl/rice_bus_arbiter_pkg.sv | 11 +
 rtl/rice_bus_if.sv | 26 ++
 rtl/pzbcm_fifo.sv | 53 +++++
 rtl/rice_bus_arbiter.sv | 114 +++++++++++
 tb/tb_rice_bus_arbiter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/rice_bus_arbiter_pkg.sv
// Shared constants and helpers for the two-requester rice bus arbiter.
package rice_bus_arbiter_pkg;

    localparam int NUM_REQ = 2;

    // Round-robin hand-off: the requester that was not just served.
    function automatic logic other_req(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/rice_bus_if.sv
// Valid/ready memory bus with a separate in-order response channel.
interface rice_bus_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    localparam int STROBE_WIDTH = DATA_WIDTH / 8;

    logic                     request_valid;
    logic                     request_ready;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [STROBE_WIDTH-1:0]  strobe;
    logic [DATA_WIDTH-1:0]    write_data;
    logic                     response_valid;
    logic                     response_ready;
    logic [DATA_WIDTH-1:0]    read_data;

    modport master (
        output request_valid, address, strobe, write_data, response_ready,
        input  request_ready, response_valid, read_data
    );

    modport slave (
        input  request_valid, address, strobe, write_data, response_ready,
        output request_ready, response_valid, read_data
    );
endinterface

// File: rtl/pzbcm_fifo.sv
// Synchronous FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module pzbcm_fifo #(
    parameter int  WIDTH = 8,
    parameter type TYPE  = logic [WIDTH-1:0],
    parameter int  DEPTH = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_empty,
    output logic o_full,
    input  logic i_push,
    input  TYPE  i_data,
    input  logic i_pop,
    output TYPE  o_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    TYPE           mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_en;
    logic          pop_en;

    assign o_empty = (count == '0);
    assign o_full  = (count == FULL_COUNT);
    assign push_en = i_push && !o_full;
    assign pop_en  = i_pop && !o_empty;
    assign o_data  = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (push_en) mem[wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            if (push_en && !pop_en)      count <= count + 1'b1;
            else if (!push_en && pop_en) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/rice_bus_arbiter.sv
// Round-robin arbiter merging the LSU (0) and IF (1) buses onto one memory bus,
// returning in-order responses to whichever requester issued each request.
module rice_bus_arbiter
    import rice_bus_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic        i_clk,
    input logic        i_rst_n,
    rice_bus_if.slave  slave_if [NUM_REQ],
    rice_bus_if.master master_if
);
    localparam int STROBE_WIDTH = DATA_WIDTH / 8;

    typedef logic req_id_t;

    logic [NUM_REQ-1:0]                    req_valid;
    logic [NUM_REQ-1:0]                    req_resp_ready;
    logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0] req_address;
    logic [NUM_REQ-1:0][STROBE_WIDTH-1:0]  req_strobe;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_write_data;

    req_id_t priority_q;
    logic    locked_q;
    req_id_t locked_id_q;
    logic    grant_valid;
    req_id_t grant_id;
    logic    req_ack;
    logic    resp_ack;
    logic    fifo_empty;
    logic    fifo_full;
    req_id_t head_id;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        localparam req_id_t ID = req_id_t'(g);

        assign req_valid[g]      = slave_if[g].request_valid;
        assign req_resp_ready[g] = slave_if[g].response_ready;
        assign req_address[g]    = slave_if[g].address;
        assign req_strobe[g]     = slave_if[g].strobe;
        assign req_write_data[g] = slave_if[g].write_data;

        assign slave_if[g].request_ready  = grant_valid && (grant_id == ID) && master_if.request_ready;
        assign slave_if[g].response_valid = !fifo_empty && (head_id == ID) && master_if.response_valid;
        assign slave_if[g].read_data      = (!fifo_empty && (head_id == ID)) ? master_if.read_data : '0;
    end

    // A full ID FIFO blocks every grant, even when a response pops in the same cycle.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = priority_q;
        if (i_rst_n && !fifo_full) begin
            if (locked_q) begin
                grant_id    = locked_id_q;
                grant_valid = req_valid[locked_id_q];
            end else if (&req_valid) begin
                grant_id    = priority_q;
                grant_valid = 1'b1;
            end else if (req_valid[0]) begin
                grant_id    = 1'b0;
                grant_valid = 1'b1;
            end else if (req_valid[1]) begin
                grant_id    = 1'b1;
                grant_valid = 1'b1;
            end
        end
    end

    // A stalled request keeps its grant until accepted so the bus never sees it withdrawn.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            priority_q  <= 1'b0;
            locked_q    <= 1'b0;
            locked_id_q <= 1'b0;
        end else begin
            locked_q <= grant_valid && !master_if.request_ready;
            if (grant_valid) locked_id_q <= grant_id;
            if (req_ack)     priority_q  <= other_req(grant_id);
        end
    end

    assign req_ack  = grant_valid && master_if.request_ready;
    assign resp_ack = !fifo_empty && master_if.response_valid && req_resp_ready[head_id];

    assign master_if.request_valid  = grant_valid;
    assign master_if.address        = grant_valid ? req_address[grant_id]    : '0;
    assign master_if.strobe         = grant_valid ? req_strobe[grant_id]     : '0;
    assign master_if.write_data     = grant_valid ? req_write_data[grant_id] : '0;
    assign master_if.response_ready = !fifo_empty && req_resp_ready[head_id];

    pzbcm_fifo #(
        .WIDTH (1),
        .TYPE  (req_id_t),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (1'b0),
        .o_empty (fifo_empty),
        .o_full  (fifo_full),
        .i_push  (req_ack),
        .i_data  (grant_id),
        .i_pop   (resp_ack),
        .o_data  (head_id)
    );

`ifndef SYNTHESIS
    response_without_request: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(master_if.response_valid && fifo_empty))
        else $error("response_valid with no outstanding request");
`endif
endmodule

// File: tb/tb_rice_bus_arbiter.sv
// Directed bench: a per-cycle vector table for arbitration/routing, then
// hand-written sequences for lock, ordering, back-pressure, full and reset.
module tb_rice_bus_arbiter;
    localparam logic [31:0] A0  = 32'h0000_0100;
    localparam logic [31:0] A1  = 32'h0000_0200;
    localparam logic [31:0] WD0 = 32'hCAFE_0000;
    localparam logic [31:0] WD1 = 32'hBEEF_0001;
    localparam logic        H   = 1'b1;
    localparam logic        L   = 1'b0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    rice_bus_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) s_bus [2] ();
    rice_bus_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) m_bus ();

    rice_bus_arbiter #(
        .ADDRESS_WIDTH   (32),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (4)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .slave_if  (s_bus),
        .master_if (m_bus)
    );

    typedef struct {
        logic        rv0;
        logic        rv1;
        logic        rdy;
        logic        resp;
        logic [37:0] exp;
    } vec_t;

    vec_t vecs [11];

    // Expected view: {m.req_valid, m.address, rr0, rr1, resp_valid0, resp_valid1, m.resp_ready}
    function automatic logic [37:0] mk(input logic mv, input logic [31:0] addr,
                                       input logic rr0, input logic rr1,
                                       input logic rsv0, input logic rsv1, input logic mrr);
        return {mv, addr, rr0, rr1, rsv0, rsv1, mrr};
    endfunction

    function automatic logic [37:0] obs();
        return {m_bus.request_valid, m_bus.address,
                s_bus[0].request_ready, s_bus[1].request_ready,
                s_bus[0].response_valid, s_bus[1].response_valid,
                m_bus.response_ready};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic rv0, input logic rv1, input logic rdy, input logic resp);
        s_bus[0].request_valid = rv0;
        s_bus[1].request_valid = rv1;
        m_bus.request_ready    = rdy;
        m_bus.response_valid   = resp;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic step_check(input string name, input logic [37:0] exp);
        @(negedge clk);
        check(name, 64'(obs()), 64'(exp));
        advance();
    endtask

    initial begin
        s_bus[0].address        = A0;
        s_bus[1].address        = A1;
        s_bus[0].write_data     = WD0;
        s_bus[1].write_data     = WD1;
        s_bus[0].strobe         = 4'hF;
        s_bus[1].strobe         = 4'h3;
        s_bus[0].response_ready = H;
        s_bus[1].response_ready = H;
        m_bus.read_data         = '0;
        drive(H, H, H, L);

        vecs[0]  = '{H, H, H, L, mk(H, A0, H, L, L, L, L)};
        vecs[1]  = '{H, H, H, H, mk(H, A1, L, H, H, L, H)};
        vecs[2]  = '{H, H, H, H, mk(H, A0, H, L, L, H, H)};
        vecs[3]  = '{H, H, H, H, mk(H, A1, L, H, H, L, H)};
        vecs[4]  = '{H, H, L, H, mk(H, A0, L, L, L, H, H)};
        vecs[5]  = '{H, H, L, L, mk(H, A0, L, L, L, L, L)};
        vecs[6]  = '{H, L, H, L, mk(H, A0, H, L, L, L, L)};
        vecs[7]  = '{H, L, H, L, mk(H, A0, H, L, L, L, H)};
        vecs[8]  = '{L, L, H, H, mk(L, '0, L, L, H, L, H)};
        vecs[9]  = '{L, H, H, H, mk(H, A1, L, H, H, L, H)};
        vecs[10] = '{L, L, H, H, mk(L, '0, L, L, L, H, H)};

        // Outputs held quiet in reset even with both requesters active.
        #3;
        check("reset_outputs", 64'(obs()), 64'(mk(L, '0, L, L, L, L, L)));
        advance();
        rst_n = H;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rv0, vecs[i].rv1, vecs[i].rdy, vecs[i].resp);
            m_bus.read_data = 32'(i);
            @(negedge clk);
            check($sformatf("vec%0d", i), 64'(obs()), 64'(vecs[i].exp));
            advance();
        end

        // Lock: requester 1 stalls while priority points at 0.
        drive(L, H, L, L); step_check("lock_first", mk(H, A1, L, L, L, L, L));
        drive(H, H, L, L); step_check("lock_hold1", mk(H, A1, L, L, L, L, L));
        step_check("lock_hold2", mk(H, A1, L, L, L, L, L));
        drive(H, H, H, L); step_check("lock_ack", mk(H, A1, L, H, L, L, L));
        @(negedge clk);
        check("after_lock", 64'(obs()), 64'(mk(H, A0, H, L, L, L, H)));
        check("after_lock_wdata", 64'(m_bus.write_data), 64'(WD0));
        advance();

        // Drain [1,0].
        drive(L, L, H, H); m_bus.read_data = 32'h11;
        @(negedge clk);
        check("drain1", 64'(obs()), 64'(mk(L, '0, L, L, L, H, H)));
        check("drain1_data", 64'(s_bus[1].read_data), 64'(32'h11));
        advance();
        m_bus.read_data = 32'h22;
        @(negedge clk);
        check("drain0", 64'(obs()), 64'(mk(L, '0, L, L, H, L, H)));
        check("drain0_data", 64'(s_bus[0].read_data), 64'(32'h22));
        advance();

        // Issue order 0,1,1 then responses A,B,C with head back-pressure first.
        drive(H, L, H, L); step_check("issue0", mk(H, A0, H, L, L, L, L));
        drive(L, H, H, L); step_check("issue1a", mk(H, A1, L, H, L, L, H));
        step_check("issue1b", mk(H, A1, L, H, L, L, H));
        drive(L, L, H, H); m_bus.read_data = 32'hA;
        s_bus[0].response_ready = L;
        step_check("head_stall", mk(L, '0, L, L, H, L, L));
        s_bus[0].response_ready = H;
        @(negedge clk);
        check("resp_a", 64'(obs()), 64'(mk(L, '0, L, L, H, L, H)));
        check("resp_a_data", 64'(s_bus[0].read_data), 64'(32'hA));
        advance();
        m_bus.read_data = 32'hB;
        @(negedge clk);
        check("resp_b", 64'(obs()), 64'(mk(L, '0, L, L, L, H, H)));
        check("resp_b_data", 64'(s_bus[1].read_data), 64'(32'hB));
        advance();
        m_bus.read_data = 32'hC;
        @(negedge clk);
        check("resp_c", 64'(obs()), 64'(mk(L, '0, L, L, L, H, H)));
        check("resp_c_data", 64'(s_bus[1].read_data), 64'(32'hC));
        advance();

        // Fill to MAX_OUTSTANDING, then block until a response frees a slot.
        drive(H, L, H, L);
        for (int k = 0; k < 4; k++)
            step_check($sformatf("fill%0d", k), mk(H, A0, H, L, L, L, (k != 0)));
        step_check("full_block", mk(L, '0, L, L, L, L, H));
        drive(H, L, H, H); m_bus.read_data = 32'h5;
        step_check("full_pop_same_cycle", mk(L, '0, L, L, H, L, H));
        drive(H, L, H, L);
        step_check("accept_after_pop", mk(H, A0, H, L, L, L, H));

        // Leave two outstanding, then reset mid-operation.
        drive(L, L, H, H);
        step_check("pre_reset_pop0", mk(L, '0, L, L, H, L, H));
        step_check("pre_reset_pop1", mk(L, '0, L, L, H, L, H));
        drive(H, H, H, H);
        #2;
        rst_n = L;
        #1;
        check("reset_mid", 64'(obs()), 64'(mk(L, '0, L, L, L, L, L)));
        drive(H, H, L, L);
        advance();
        rst_n = H;
        step_check("post_reset_state", mk(H, A0, L, L, L, L, L));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
